// File: rtl/reindeer_data_access_pkg.sv
// Shared data-side definitions: word geometry, access-width encodings and
// the store-path helpers used by the load/store unit.
package reindeer_data_access_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned XLEN_BYTES         = XLEN / 8;
  localparam int unsigned DATA_MEM_ADDR_BITS = 14;

  localparam logic [1:0] WIDTH_BYTE    = 2'b00;
  localparam logic [1:0] WIDTH_HALF    = 2'b01;
  localparam logic [1:0] WIDTH_WORD    = 2'b10;
  localparam logic [1:0] WIDTH_ILLEGAL = 2'b11;

  function automatic logic access_misaligned(input logic [1:0] width,
                                             input logic [1:0] offset);
    logic bad;
    case (width)
      WIDTH_BYTE: bad = 1'b0;
      WIDTH_HALF: bad = offset[0];
      WIDTH_WORD: bad = (offset != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [XLEN_BYTES-1:0] store_mask(input logic [1:0] width,
                                                       input logic [1:0] offset);
    logic [XLEN_BYTES-1:0] mask;
    case (width)
      WIDTH_BYTE: mask = XLEN_BYTES'(1) << offset;
      WIDTH_HALF: mask = XLEN_BYTES'(3) << offset;
      default:    mask = '1;
    endcase
    return mask;
  endfunction

  // Store operand is replicated so every enabled byte lane carries the data.
  function automatic logic [XLEN-1:0] store_replicate(input logic [1:0]      width,
                                                      input logic [XLEN-1:0] data);
    logic [XLEN-1:0] word;
    case (width)
      WIDTH_BYTE: word = {(XLEN/8){data[7:0]}};
      WIDTH_HALF: word = {(XLEN/16){data[15:0]}};
      default:    word = data;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/reindeer_load_align.sv
// Load return extraction: picks the addressed byte/half lane of the memory
// word and sign- or zero-extends it to XLEN.
module reindeer_load_align
  import reindeer_data_access_pkg::*;
(
  input  logic [XLEN-1:0] word_in,
  input  logic [1:0]      offset,
  input  logic [1:0]      width,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_in[7:0];
    case (offset)
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      2'd3:    byte_sel = word_in[31:24];
      default: byte_sel = word_in[7:0];
    endcase
    half_sel = offset[1] ? word_in[31:16] : word_in[15:0];

    case (width)
      WIDTH_BYTE: data_c = {{(XLEN-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
      WIDTH_HALF: data_c = {{(XLEN-16){half_sel[15] & ~is_unsigned}}, half_sel};
      default:    data_c = word_in;
    endcase
  end

endmodule

// File: rtl/reindeer_data_access.sv
// Load/store unit data-memory sequencer: accepts one request, checks
// alignment, issues it on the shared memory port and reports completion.
module reindeer_data_access
  import reindeer_data_access_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = DATA_MEM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_load,
  input  logic                     req_store,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [1:0]               req_width,
  input  logic                     req_unsigned,
  input  logic [XLEN-1:0]          req_store_data,
  input  logic                     data_grant,
  output logic                     data_read_enable,
  output logic [XLEN_BYTES-1:0]    data_write_enable,
  output logic [MEM_ADDR_BITS-1:0] data_rw_addr,
  output logic [XLEN-1:0]          data_write_word,
  input  logic                     mem_enable_in,
  input  logic [XLEN-1:0]          mem_word_in,
  output logic                     load_done,
  output logic [XLEN-1:0]          load_data,
  output logic                     store_done,
  output logic                     misaligned_exception,
  output logic [XLEN-1:0]          exception_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ_WAIT} state_e;

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     is_load_q, is_load_d;
  logic [1:0]               offset_q, offset_d;
  logic [1:0]               width_q, width_d;
  logic                     unsigned_q, unsigned_d;
  logic                     read_en_q, read_en_d;
  logic [XLEN_BYTES-1:0]    write_en_q, write_en_d;
  logic [MEM_ADDR_BITS-1:0] rw_addr_q, rw_addr_d;
  logic [XLEN-1:0]          write_word_q, write_word_d;
  logic                     load_done_q, load_done_d;
  logic [XLEN-1:0]          load_data_q, load_data_d;
  logic                     store_done_q, store_done_d;
  logic                     misaligned_q, misaligned_d;
  logic [XLEN-1:0]          exc_addr_q, exc_addr_d;
  logic [XLEN-1:0]          load_aligned_c;

  reindeer_load_align u_load_align (
    .word_in     (mem_word_in),
    .offset      (offset_q),
    .width       (width_q),
    .is_unsigned (unsigned_q),
    .data_c      (load_aligned_c)
  );

  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    offset_d     = offset_q;
    width_d      = width_q;
    unsigned_d   = unsigned_q;
    read_en_d    = read_en_q;
    write_en_d   = write_en_q;
    rw_addr_d    = rw_addr_q;
    write_word_d = write_word_q;
    load_data_d  = load_data_q;
    exc_addr_d   = exc_addr_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    misaligned_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && (req_load || req_store)) begin
          is_load_d  = req_load;
          offset_d   = req_addr[1:0];
          width_d    = req_width;
          unsigned_d = req_unsigned;
          if (access_misaligned(req_width, req_addr[1:0])) begin
            misaligned_d = 1'b1;
            exc_addr_d   = req_addr;
          end else begin
            state_d      = S_ISSUE;
            rw_addr_d    = req_addr[MEM_ADDR_BITS+1:2];
            write_word_d = store_replicate(req_width, req_store_data);
            read_en_d    = req_load;
            write_en_d   = req_load ? '0 : store_mask(req_width, req_addr[1:0]);
          end
        end
      end
      // Without a grant every request output simply holds.
      S_ISSUE: begin
        if (data_grant) begin
          read_en_d  = 1'b0;
          write_en_d = '0;
          if (is_load_q) begin
            state_d = S_READ_WAIT;
          end else begin
            store_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_READ_WAIT: begin
        if (mem_enable_in) begin
          load_data_d = load_aligned_c;
          load_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);

    if (sync_reset) begin
      state_d      = S_IDLE;
      ready_d      = 1'b1;
      is_load_d    = 1'b0;
      offset_d     = 2'b00;
      width_d      = WIDTH_BYTE;
      unsigned_d   = 1'b0;
      read_en_d    = 1'b0;
      write_en_d   = '0;
      rw_addr_d    = '0;
      write_word_d = '0;
      load_data_d  = '0;
      exc_addr_d   = '0;
      load_done_d  = 1'b0;
      store_done_d = 1'b0;
      misaligned_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      is_load_q    <= 1'b0;
      offset_q     <= 2'b00;
      width_q      <= WIDTH_BYTE;
      unsigned_q   <= 1'b0;
      read_en_q    <= 1'b0;
      write_en_q   <= '0;
      rw_addr_q    <= '0;
      write_word_q <= '0;
      load_data_q  <= '0;
      exc_addr_q   <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      is_load_q    <= is_load_d;
      offset_q     <= offset_d;
      width_q      <= width_d;
      unsigned_q   <= unsigned_d;
      read_en_q    <= read_en_d;
      write_en_q   <= write_en_d;
      rw_addr_q    <= rw_addr_d;
      write_word_q <= write_word_d;
      load_data_q  <= load_data_d;
      exc_addr_q   <= exc_addr_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign req_ready            = ready_q;
  assign data_read_enable     = read_en_q;
  assign data_write_enable    = write_en_q;
  assign data_rw_addr         = rw_addr_q;
  assign data_write_word      = write_word_q;
  assign load_done            = load_done_q;
  assign load_data            = load_data_q;
  assign store_done           = store_done_q;
  assign misaligned_exception = misaligned_q;
  assign exception_addr       = exc_addr_q;

endmodule
